asg_lin: RTL and testbench
==========================

// Module: asg_lin
// PURPOSE
//  Linear output stage directly downstream of the per-channel ASG stream: y = sat(x*mul/2**(DWM-2) + sum).
//  Consumes the ASG AXI4-Stream and produces a gain/offset-corrected, saturated stream for the DAC interface.
//  Two-cycle pipeline with full AXI4-Stream backpressure; TLAST carried alongside data.
// PARAMETERS
//  DWI = 14  input sample width, signed (sti.TDATA[DWI-1:0])
//  DWO = 14  output sample width, signed (sto.TDATA[DWO-1:0])
//  DWM = 16  gain width, signed fixed point s2.(DWM-2); 1.0 = 2**(DWM-2)
//  DWS = 14  offset width, signed, in output LSB units
//  DWC = 32  saturation event counter width
// PORTS
//  clk      in   1    clock; sti/sto ACLK is the same net and is not used inside
//  rst      in   1    synchronous reset, active-high; sti/sto ARESETn not used
//  sti      axi4_stream_if.d  -  input stream (from ASG)
//  sto      axi4_stream_if.s  -  output stream (to DAC)
//  ctl_rst  in   1    synchronous pipeline flush, same effect as rst on pipeline and counter
//  ctl_upd  in   1    single-cycle pulse: copy cfg_mul/cfg_sum into shadow registers
//  cfg_mul  in   DWM  gain, signed
//  cfg_sum  in   DWS  offset, signed
//  sts_sat  out  DWC  saturated output beat count
// BEHAVIOUR
//  - One clock, reset synchronous and active-high. On rst: stage valids=0, sto.TVALID=0, sto.TLAST=0,
//    sto.TDATA=0, shadow mul=2**(DWM-2) (unity), shadow sum=0, sts_sat=0. sto.TKEEP is constant '1.
//  - Pipeline enable ce = sto.TREADY | ~sto.TVALID; sti.TREADY = ce (combinational, no internal stall source).
//  - S1 (on ce): s1_vld<=sti.TVALID; s1_prd<=sti.TDATA*mul_shd (DWI+DWM bits, full precision); s1_lst<=sti.TLAST.
//  - S2 (on ce): sum = (s1_prd >>> (DWM-2)) + sign-extended sum_shd, computed at DWI+DWM+1 bits (no overflow);
//    clamp to [-2**(DWO-1), 2**(DWO-1)-1]; register to sto.TDATA; sto.TVALID<=s1_vld; sto.TLAST<=s1_lst.
//  - Shift is arithmetic truncation toward -inf; no rounding.
//  - Latency: accepted beat appears on sto 2 cycles later with TREADY held high; throughput 1 beat/cycle.
//  - Stall: TREADY low with TVALID high freezes all stages and data; no beat dropped or duplicated.
//  - Bubbles (sti.TVALID=0) propagate as TVALID=0; they are not collapsed.
//  - ctl_upd: shadow regs load at that edge; a beat entering S1 in the same cycle uses the OLD values;
//    the next accepted beat uses the new. ctl_upd while stalled still loads; affects beats not yet in S1.
//  - ctl_rst: same cycle-level clear as rst for valids, TLAST, sts_sat; shadow regs kept. ctl_rst has priority
//    over ce and ctl_upd for pipeline state; ctl_upd still loads in the same cycle.
//  - rst/ctl_rst mid-beat with sto.TVALID=1 & TREADY=0 drops in-flight beats (documented, intended).
// CONFIGURATION
//  - ASG_LIN_SAT_CNT_EN defined: sts_sat increments by 1 on every output handshake (TVALID&TREADY) whose
//    value was clamped; saturates at 2**DWC-1 (no wrap); cleared by rst/ctl_rst. One extra flag bit per stage.
//  - Not defined: sts_sat tied to '0; flag logic absent. Datapath identical either way.
// STRUCTURE
//  - Package asg_lin_pkg: typedefs for input sample, output sample, gain, offset; localparams for unity gain
//    (2**(DWM-2)), output min/max; function sat() returning clamped value plus clamp flag.
//  - One sub-module, asg_lin_sat: combinational add + clamp (S2 logic), reused for a future offset-only stage.
//  - Shadow regs, pipeline regs and counter live in asg_lin.
// TESTING (DWI=DWO=14, DWM=16, DWS=14)
//  1 unity: reset, send x=4096, 1000, -1 with TREADY=1 -> out 4096, 1000, -1 exactly 2 cycles after each accept.
//  2 pos sat: ctl_upd mul=0x7FFF sum=0, x=8191 -> out 8191, sts_sat=1 (macro on) / 0 (macro off).
//  3 neg sat: mul=0x7FFF sum=-100, x=-8192 -> out -8192; x=0 -> out -100; sts_sat increments once.
//  4 backpressure: stream 0..31 ramp, TREADY low cycles 5-9 and random 50% -> 32 outputs, in order, no dup,
//    TDATA/TLAST stable while stalled; TLAST on input beat 31 appears only on output beat 31.
//  5 update timing: ctl_upd (mul=0x2000) in same cycle as accept of beat A -> A unscaled, beat B halved.
//  6 flush: ctl_rst with 2 beats in flight and TREADY=0 -> next cycle TVALID=0, sts_sat=0; mul keeps 0x2000.

Source files
------------

// File: rtl/asg_lin_pkg.sv
// Shared types, constants and the clamp helper for the asg_lin linear output stage.
// Widths are fixed here so that every file in the slice agrees on them.
package asg_lin_pkg;

   localparam int DWI = 14;  // input sample width
   localparam int DWO = 14;  // output sample width
   localparam int DWM = 16;  // gain width, s2.(DWM-2)
   localparam int DWS = 14;  // offset width, output LSB units
   localparam int DWC = 32;  // saturation counter width
   localparam int DWP = DWI + DWM;  // full-precision product
   localparam int DWA = DWP + 1;    // product plus offset, cannot overflow

   typedef logic signed [DWI-1:0] din_t;
   typedef logic signed [DWO-1:0] dout_t;
   typedef logic signed [DWM-1:0] mul_t;
   typedef logic signed [DWS-1:0] sum_t;
   typedef logic signed [DWP-1:0] prd_t;
   typedef logic signed [DWA-1:0] acc_t;

   localparam mul_t MUL_ONE = mul_t'(2 ** (DWM - 2));
   localparam acc_t OUT_MAX = acc_t'(2 ** (DWO - 1) - 1);
   localparam acc_t OUT_MIN = acc_t'(-(2 ** (DWO - 1)));

   typedef struct packed {
      dout_t val;
      logic  clp;
   } sat_t;

   function automatic sat_t sat(input acc_t a);
      sat_t r;
      if (a > OUT_MAX) begin
         r.val = dout_t'(OUT_MAX);
         r.clp = 1'b1;
      end else if (a < OUT_MIN) begin
         r.val = dout_t'(OUT_MIN);
         r.clp = 1'b1;
      end else begin
         r.val = dout_t'(a);
         r.clp = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/asg_lin_if.sv
// AXI4-Stream bundle between the ASG, the linear stage and the DAC interface.
// s/master is the producing side, d/slave the consuming side.
interface axi4_stream_if #(
   parameter int DW = 14
) ();
   localparam int KW = (DW + 7) / 8;

   logic [DW-1:0] TDATA;
   logic [KW-1:0] TKEEP;
   logic          TVALID;
   logic          TREADY;
   logic          TLAST;

   modport s      (output TDATA, TKEEP, TVALID, TLAST, input  TREADY);
   modport d      (input  TDATA, TKEEP, TVALID, TLAST, output TREADY);
   modport master (output TDATA, TKEEP, TVALID, TLAST, input  TREADY);
   modport slave  (input  TDATA, TKEEP, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/asg_lin_sat.sv
// Offset add and output clamp: y = sat((prd >>> (DWM-2)) + ofs), flag set when clamped.
// Purely combinational; the shift truncates toward -inf.
module asg_lin_sat
   import asg_lin_pkg::*;
(
   input  prd_t  prd,
   input  sum_t  ofs,
   output dout_t y,
   output logic  clp
);
   acc_t acc;
   sat_t res;

   always_comb begin
      acc = acc_t'(prd >>> (DWM - 2)) + acc_t'(ofs);
      res = sat(acc);
   end

   assign y   = res.val;
   assign clp = res.clp;
endmodule

// File: rtl/asg_lin.sv
// Two-stage gain/offset/saturate stage on an AXI4-Stream with full backpressure.
// Define ASG_LIN_SAT_CNT_EN to build the saturated-beat counter on sts_sat.
module asg_lin
   import asg_lin_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   axi4_stream_if.d          sti,
   axi4_stream_if.s          sto,
   input  logic              ctl_rst,
   input  logic              ctl_upd,
   input  mul_t              cfg_mul,
   input  sum_t              cfg_sum,
   output logic [DWC-1:0]    sts_sat
);
   logic  ce;
   logic  flush;
   din_t  x_in;
   prd_t  prd_next;

   mul_t  mul_shd_reg;
   sum_t  sum_shd_reg;

   logic  s1_vld_reg;
   logic  s1_lst_reg;
   prd_t  s1_prd_reg;
   sum_t  s1_sum_reg;

   logic  out_vld_reg;
   logic  out_lst_reg;
   dout_t out_dat_reg;

   dout_t s2_y;
   logic  s2_clp;

   assign ce         = sto.TREADY | ~out_vld_reg;
   assign flush      = rst | ctl_rst;
   assign sti.TREADY = ce;

   assign sto.TVALID = out_vld_reg;
   assign sto.TLAST  = out_lst_reg;
   assign sto.TDATA  = out_dat_reg;
   assign sto.TKEEP  = '1;

   assign x_in     = din_t'(sti.TDATA[DWI-1:0]);
   assign prd_next = prd_t'(x_in) * prd_t'(mul_shd_reg);

   // Shadow registers survive ctl_rst; only a full reset restores unity gain.
   always_ff @(posedge clk) begin
      if (rst) begin
         mul_shd_reg <= MUL_ONE;
         sum_shd_reg <= '0;
      end else if (ctl_upd) begin
         mul_shd_reg <= cfg_mul;
         sum_shd_reg <= cfg_sum;
      end
   end

   // The offset travels with the beat so a beat uses one coherent gain/offset pair.
   always_ff @(posedge clk) begin
      if (flush) begin
         s1_vld_reg <= 1'b0;
         s1_lst_reg <= 1'b0;
      end else if (ce) begin
         s1_vld_reg <= sti.TVALID;
         s1_lst_reg <= sti.TLAST;
         s1_prd_reg <= prd_next;
         s1_sum_reg <= sum_shd_reg;
      end
   end

   asg_lin_sat u_sat (
      .prd (s1_prd_reg),
      .ofs (s1_sum_reg),
      .y   (s2_y),
      .clp (s2_clp)
   );

   always_ff @(posedge clk) begin
      if (flush) begin
         out_vld_reg <= 1'b0;
         out_lst_reg <= 1'b0;
         out_dat_reg <= '0;
      end else if (ce) begin
         out_vld_reg <= s1_vld_reg;
         out_lst_reg <= s1_lst_reg;
         out_dat_reg <= s2_y;
      end
   end

`ifdef ASG_LIN_SAT_CNT_EN
   logic           out_clp_reg;
   logic [DWC-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (flush) begin
         out_clp_reg <= 1'b0;
      end else if (ce) begin
         out_clp_reg <= s2_clp;
      end
   end

   // Count only beats the sink actually took; stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (flush) begin
         cnt_reg <= '0;
      end else if (out_vld_reg && sto.TREADY && out_clp_reg && !(&cnt_reg)) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign sts_sat = cnt_reg;
`else
   logic clp_unused;
   assign clp_unused = s2_clp;
   assign sts_sat    = '0;
`endif

endmodule

// File: tb/tb_asg_lin.sv
// Randomized and directed bench for asg_lin against a queue-based behavioural model.
// Honours ASG_LIN_SAT_CNT_EN for the expected saturation count.
module tb_asg_lin;

`ifdef ASG_LIN_SAT_CNT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               ctl_rst = 1'b0;
   logic               ctl_upd = 1'b0;
   logic signed [15:0] cfg_mul = '0;
   logic signed [13:0] cfg_sum = '0;
   logic [31:0]        sts_sat;

   axi4_stream_if #(.DW(14)) sti_if ();
   axi4_stream_if #(.DW(14)) sto_if ();

   asg_lin dut (
      .clk     (clk),
      .rst     (rst),
      .sti     (sti_if),
      .sto     (sto_if),
      .ctl_rst (ctl_rst),
      .ctl_upd (ctl_upd),
      .cfg_mul (cfg_mul),
      .cfg_sum (cfg_sum),
      .sts_sat (sts_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      int y;
      bit lst;
      bit clp;
      int cyc;
   } ent_t;

   ent_t    q[$];
   int      obs[$];
   int      n_cmp = 0;
   int      n_bad = 0;
   int      cyc = 0;
   int      acc_cnt = 0;
   int      mul_m = 16384;
   int      sum_m = 0;
   longint  cnt_m = 0;
   bit      chk_lat = 1'b0;
   int      rdy_mode = 0;
   int      tcyc = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic int model_y(input int x, input int m, input int s, output bit clp);
      int v;
      v   = ((x * m) >>> 14) + s;
      clp = 1'b0;
      if (v > 8191) begin
         v   = 8191;
         clp = 1'b1;
      end else if (v < -8192) begin
         v   = -8192;
         clp = 1'b1;
      end
      return v;
   endfunction

   // Model: evaluated at the edge on pre-edge values.
   always @(posedge clk) begin
      ent_t e;
      bit   c;
      cyc++;
      if (sti_if.TVALID && (sto_if.TREADY || !sto_if.TVALID)) acc_cnt++;
      if (rst || ctl_rst) begin
         q.delete();
         cnt_m = 0;
      end else begin
         if (sto_if.TVALID && sto_if.TREADY) begin
            if (q.size() == 0) begin
               chk("pop_underflow", 1, 0);
            end else begin
               e = q.pop_front();
               obs.push_back(int'($signed(sto_if.TDATA)));
               if (chk_lat) chk("latency", cyc - e.cyc, 2);
               if (SAT_EN && e.clp && cnt_m < 64'hFFFF_FFFF) cnt_m++;
            end
         end
         if (sti_if.TVALID && (sto_if.TREADY || !sto_if.TVALID)) begin
            e.y   = model_y(int'($signed(sti_if.TDATA)), mul_m, sum_m, c);
            e.clp = c;
            e.lst = sti_if.TLAST;
            e.cyc = cyc;
            q.push_back(e);
         end
      end
      if (rst) begin
         mul_m = 16384;
         sum_m = 0;
      end else if (ctl_upd) begin
         mul_m = int'(cfg_mul);
         sum_m = int'(cfg_sum);
      end
   end

   // Compare process: outputs against the model on every cycle.
   always @(negedge clk) begin
      if (!rst) begin
         chk("sti_tready", longint'(sti_if.TREADY), longint'(sto_if.TREADY || !sto_if.TVALID));
         chk("sts_sat", longint'(sts_sat), cnt_m);
         if (sto_if.TVALID) begin
            if (q.size() == 0) begin
               chk("spurious_valid", 1, 0);
            end else begin
               chk("tdata", longint'($signed(sto_if.TDATA)), longint'(q[0].y));
               chk("tlast", longint'(sto_if.TLAST), longint'(q[0].lst));
            end
         end
      end
   end

   // Sink ready pattern.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1:       sto_if.TREADY = (tcyc >= 5 && tcyc <= 9) ? 1'b0 : 1'($urandom_range(0, 1));
         2:       sto_if.TREADY = 1'b0;
         3:       sto_if.TREADY = 1'($urandom_range(0, 1));
         default: sto_if.TREADY = 1'b1;
      endcase
      tcyc++;
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int x, input bit lst, input bit upd, input int m, input int s);
      int start;
      int t;
      sti_if.TVALID = 1'b1;
      sti_if.TDATA  = 14'(x);
      sti_if.TLAST  = lst;
      if (upd) begin
         ctl_upd = 1'b1;
         cfg_mul = 16'(m);
         cfg_sum = 14'(s);
      end
      start = acc_cnt;
      for (t = 0; t < 200; t++) begin
         @(posedge clk);
         #1;
         ctl_upd = 1'b0;
         if (acc_cnt != start) break;
      end
      if (t == 200) chk("accept_timeout", acc_cnt - start, 1);
      sti_if.TVALID = 1'b0;
      sti_if.TLAST  = 1'b0;
   endtask

   task automatic upd(input int m, input int s);
      ctl_upd = 1'b1;
      cfg_mul = 16'(m);
      cfg_sum = 14'(s);
      idle(1);
      ctl_upd = 1'b0;
   endtask

   task automatic drain();
      int t;
      for (t = 0; t < 1000 && q.size() != 0; t++) idle(1);
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
      idle(1);
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      sti_if.TVALID = 1'b0;
      sti_if.TDATA  = '0;
      sti_if.TLAST  = 1'b0;
      sti_if.TKEEP  = '1;
      sto_if.TREADY = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tvalid", longint'(sto_if.TVALID), 0);
      chk("rst_tlast", longint'(sto_if.TLAST), 0);
      chk("rst_tdata", longint'(sto_if.TDATA), 0);
      chk("rst_sts_sat", longint'(sts_sat), 0);
      chk("tkeep", longint'(sto_if.TKEEP), 3);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);

      // 1: unity gain, two-cycle latency
      b = obs.size();
      chk_lat = 1'b1;
      send(4096, 0, 0, 0, 0);
      send(1000, 0, 0, 0, 0);
      send(-1, 0, 0, 0, 0);
      drain();
      chk_lat = 1'b0;
      chk("t1_count", obs.size() - b, 3);
      if (obs.size() - b == 3) begin
         chk("t1_y0", obs[b], 4096);
         chk("t1_y1", obs[b+1], 1000);
         chk("t1_y2", obs[b+2], -1);
      end

      // 2: positive saturation
      upd(16'h7FFF, 0);
      b = obs.size();
      send(8191, 0, 0, 0, 0);
      drain();
      if (obs.size() > b) chk("t2_y", obs[b], 8191);
      else chk("t2_count", obs.size() - b, 1);
      chk("t2_sts_sat", longint'(sts_sat), SAT_EN ? 1 : 0);

      // 3: negative saturation and offset
      upd(16'h7FFF, -100);
      b = obs.size();
      send(-8192, 0, 0, 0, 0);
      send(0, 0, 0, 0, 0);
      drain();
      chk("t3_count", obs.size() - b, 2);
      if (obs.size() - b == 2) begin
         chk("t3_y0", obs[b], -8192);
         chk("t3_y1", obs[b+1], -100);
      end
      chk("t3_sts_sat", longint'(sts_sat), SAT_EN ? 2 : 0);

      // 4: ramp under backpressure
      rst_pulse();
      rdy_mode = 1;
      tcyc = 0;
      b = obs.size();
      for (int i = 0; i < 32; i++) begin
         send(i, i == 31, 0, 0, 0);
         idle($urandom_range(0, 1));
      end
      drain();
      rdy_mode = 0;
      idle(2);
      chk("t4_count", obs.size() - b, 32);
      if (obs.size() - b == 32) begin
         for (int i = 0; i < 32; i++) chk($sformatf("t4_y%0d", i), obs[b+i], i);
      end

      // 5: update coincident with accept of beat A
      b = obs.size();
      send(1000, 0, 1, 16'h2000, 0);
      send(1000, 0, 0, 0, 0);
      drain();
      chk("t5_count", obs.size() - b, 2);
      if (obs.size() - b == 2) begin
         chk("t5_a", obs[b], 1000);
         chk("t5_b", obs[b+1], 500);
      end

      // 6: flush with beats in flight and the sink stalled
      rdy_mode = 2;
      idle(2);
      send(300, 0, 0, 0, 0);
      send(300, 1, 0, 0, 0);
      idle(1);
      ctl_rst = 1'b1;
      @(posedge clk);
      #1;
      ctl_rst = 1'b0;
      @(negedge clk);
      chk("t6_tvalid", longint'(sto_if.TVALID), 0);
      chk("t6_sts_sat", longint'(sts_sat), 0);
      @(posedge clk);
      #1;
      rdy_mode = 0;
      idle(2);
      b = obs.size();
      send(1000, 0, 0, 0, 0);
      drain();
      if (obs.size() > b) chk("t6_y", obs[b], 500);
      else chk("t6_count", obs.size() - b, 1);

      // Random traffic with random updates, stalls and occasional flushes
      rdy_mode = 3;
      for (int i = 0; i < 400; i++) begin
         int x;
         int m;
         int s;
         bit u;
         case ($urandom_range(0, 7))
            0:       x = 8191;
            1:       x = -8192;
            default: x = int'($urandom_range(0, 16383)) - 8192;
         endcase
         m = int'($urandom_range(0, 65535)) - 32768;
         s = int'($urandom_range(0, 16383)) - 8192;
         u = ($urandom_range(0, 5) == 0);
         send(x, ($urandom_range(0, 7) == 0), u, m, s);
         idle($urandom_range(0, 2));
         if ($urandom_range(0, 49) == 0) begin
            ctl_rst = 1'b1;
            idle(1);
            ctl_rst = 1'b0;
         end
      end
      drain();
      rdy_mode = 0;
      idle(2);
      chk("final_queue_empty", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
